// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed 7-segment bus observed by the scan decoder,
// plus the recovered per-digit register file.
// SEG7_DP_EN adds the decimal-point line and its captured copy.
interface seg7_scan_decoder_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   an_n;
   logic [4*DIGITS-1:0] hex_out;
   logic [DIGITS-1:0]   digit_valid;
   logic                update;
   logic [IDX_W-1:0]    upd_digit;
   logic                bad_pattern;
`ifdef SEG7_DP_EN
   logic                seg_dp_n;
   logic [DIGITS-1:0]   dp_out;

   modport master (
      output seg_n, an_n, seg_dp_n,
      input  hex_out, digit_valid, update, upd_digit, bad_pattern, dp_out
   );
   modport slave (
      input  seg_n, an_n, seg_dp_n,
      output hex_out, digit_valid, update, upd_digit, bad_pattern, dp_out
   );
`else
   modport master (
      output seg_n, an_n,
      input  hex_out, digit_valid, update, upd_digit, bad_pattern
   );
   modport slave (
      input  seg_n, an_n,
      output hex_out, digit_valid, update, upd_digit, bad_pattern
   );
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches an active-low multiplexed 7-segment bus and
// recovers the hex nibble shown on each digit once the pattern has been
// stable for STABLE_CYCLES matching samples.
// Optional feature macro: SEG7_DP_EN (decimal point capture into dp_out).
module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_decoder_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEG7_DP_EN
   localparam int SMP_W = 8 + DIGITS;
`else
   localparam int SMP_W = 7 + DIGITS;
`endif

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [SMP_W-1:0]    smp_d, smp_q;
   logic                sel;
   logic [IDX_W-1:0]    idx;
   int unsigned         nz;
   logic                capture;
   logic [4:0]          dec;
   logic                blank;

   logic [4*DIGITS-1:0] hex_q;
   logic [DIGITS-1:0]   valid_q;
   logic                update_q;
   logic [IDX_W-1:0]    upd_digit_q;
   logic                bad_q;

   // {legal, nibble} for a raw active-low segment pattern
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = 5'h10;
         7'b1111001: decode = 5'h11;
         7'b0100100: decode = 5'h12;
         7'b0110000: decode = 5'h13;
         7'b0011001: decode = 5'h14;
         7'b0010010: decode = 5'h15;
         7'b0000010: decode = 5'h16;
         7'b1011000: decode = 5'h17;
         7'b0000000: decode = 5'h18;
         7'b0010000: decode = 5'h19;
         7'b0001000: decode = 5'h1A;
         7'b0000011: decode = 5'h1B;
         7'b1000110: decode = 5'h1C;
         7'b0100001: decode = 5'h1D;
         7'b0000110: decode = 5'h1E;
         7'b0001110: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

`ifdef SEG7_DP_EN
   assign smp_d = {bus.seg_dp_n, bus.seg_n, bus.an_n};
`else
   assign smp_d = {bus.seg_n, bus.an_n};
`endif
   assign dec   = decode(bus.seg_n);
   assign blank = (bus.seg_n == 7'h7F);

   // Selectability of the incoming sample: exactly one enable low, and which
   always_comb begin
      nz  = 0;
      idx = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (!bus.an_n[k]) begin
            nz  = nz + 1;
            idx = IDX_W'(k);
         end
      end
      sel = (nz == 1);
   end

   // Input sample register, FSM state and stability counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_q   <= '1;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         smp_q   <= smp_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: incoming sample is compared against the registered one, so
   // the edge that loads a new value is e1 and capture lands on e(N+1)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!sel) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (smp_d != smp_q) begin
         state_d = SETTLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            SETTLE: begin
               if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
               if (cnt_d >= 8'(STABLE_CYCLES)) begin
                  state_d = HOLD;
                  capture = 1'b1;
               end
            end
            HOLD: ;
            default: begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Per-digit register file and capture pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_q       <= '0;
         valid_q     <= '0;
         update_q    <= 1'b0;
         upd_digit_q <= '0;
         bad_q       <= 1'b0;
      end else begin
         update_q <= capture;
         bad_q    <= 1'b0;
         if (capture) begin
            upd_digit_q <= idx;
            if (dec[4]) begin
               hex_q[{idx, 2'b00} +: 4] <= dec[3:0];
               valid_q[idx]             <= 1'b1;
            end else if (blank) begin
               valid_q[idx] <= 1'b0;
            end else begin
               bad_q <= 1'b1;
            end
         end
      end
   end

`ifdef SEG7_DP_EN
   logic [DIGITS-1:0] dp_q;

   // Decimal point follows every capture regardless of pattern legality
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          dp_q      <= '0;
      else if (capture) dp_q[idx] <= ~bus.seg_dp_n;
   end

   assign bus.dp_out = dp_q;
`endif

   assign bus.hex_out     = hex_q;
   assign bus.digit_valid = valid_q;
   assign bus.update      = update_q;
   assign bus.upd_digit   = upd_digit_q;
   assign bus.bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: drives display patterns, predicts captures with a
// small model and checks them against a scoreboard when update pulses.
module tb_seg7_scan_decoder;
   localparam int N = 3;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] nib;
   } vec_t;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  idx;
      logic        bad;
      logic [15:0] hex;
      logic [3:0]  valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   vec_t        tbl[16];
   exp_t        sbq[$];
   logic [15:0] m_hex   = '0;
   logic [3:0]  m_valid = '0;
   logic [10:0] m_last  = '1;
   logic        m_cap   = 1'b0;
   int unsigned m_run   = 0;
   int unsigned m_start = 0;

   seg7_scan_decoder_if #(.DIGITS(4)) bus ();

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Posedge counter used for latency expectations
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ref_decode(input logic [6:0] s);
      ref_decode = -1;
      for (int i = 0; i < 16; i++)
         if (tbl[i].seg == s) ref_decode = int'(tbl[i].nib);
   endfunction

   // Present a pattern for a number of edges; predict any capture it causes
   task automatic hold(input logic [6:0] seg, input logic [3:0] an, input int unsigned cycles);
      logic [10:0] key;
      logic        late;
      exp_t        e;
      int          d;
      int unsigned ix;
      bus.seg_n = seg;
      bus.an_n  = an;
      key = {seg, an};
      if ($countones(~an) != 1) begin
         m_run = 0;
         m_cap = 1'b0;
      end else if (key != m_last) begin
         m_start = cyc;
         m_run   = cycles;
         m_cap   = 1'b0;
      end else begin
         m_run = m_run + cycles;
      end
      m_last = key;
      if ($countones(~an) == 1 && !m_cap && m_run >= N + 1) begin
         m_cap = 1'b1;
         ix = 0;
         for (int unsigned k = 0; k < 4; k++) if (!an[k]) ix = k;
         d = ref_decode(seg);
         e.bad = 1'b0;
         if (d >= 0) begin
            m_hex[4*ix +: 4] = 4'(d);
            m_valid[ix]      = 1'b1;
         end else if (seg == 7'h7F) begin
            m_valid[ix] = 1'b0;
         end else begin
            e.bad = 1'b1;
         end
         e.cyc   = m_start + N + 1;
         e.idx   = 2'(ix);
         e.hex   = m_hex;
         e.valid = m_valid;
         sbq.push_back(e);
      end
      repeat (cycles) @(negedge clk);
      late = (sbq.size() != 0) && (sbq[0].cyc < cyc);
      chk("capture_on_time", 32'(late), 0);
      if (late) void'(sbq.pop_front());
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge
   task automatic pulse_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_hex_out",     32'(bus.hex_out), 0);
      chk("rst_digit_valid", 32'(bus.digit_valid), 0);
      chk("rst_update",      32'(bus.update), 0);
      chk("rst_upd_digit",   32'(bus.upd_digit), 0);
      chk("rst_bad_pattern", 32'(bus.bad_pattern), 0);
      bus.seg_n = '1;
      bus.an_n  = '1;
      #1 rst = 1'b0;
      sbq.delete();
      m_hex   = '0;
      m_valid = '0;
      m_last  = '1;
      m_cap   = 1'b0;
      m_run   = 0;
      @(negedge clk);
   endtask

   // Scoreboard consumer: every update must match the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("bad_only_with_update", 32'(bus.bad_pattern & ~bus.update), 0);
         if (bus.update) begin
            chk("update_expected", 32'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("update_cycle", cyc, e.cyc);
               chk("upd_digit",    32'(bus.upd_digit), 32'(e.idx));
               chk("bad_pattern",  32'(bus.bad_pattern), 32'(e.bad));
               chk("hex_out",      32'(bus.hex_out), 32'(e.hex));
               chk("digit_valid",  32'(bus.digit_valid), 32'(e.valid));
            end
         end
      end
   end

`ifdef SEG7_DP_EN
   initial bus.seg_dp_n = 1'b1;
`endif

   initial begin
      tbl[0]  = '{7'b1000000, 4'h0};
      tbl[1]  = '{7'b1111001, 4'h1};
      tbl[2]  = '{7'b0100100, 4'h2};
      tbl[3]  = '{7'b0110000, 4'h3};
      tbl[4]  = '{7'b0011001, 4'h4};
      tbl[5]  = '{7'b0010010, 4'h5};
      tbl[6]  = '{7'b0000010, 4'h6};
      tbl[7]  = '{7'b1011000, 4'h7};
      tbl[8]  = '{7'b0000000, 4'h8};
      tbl[9]  = '{7'b0010000, 4'h9};
      tbl[10] = '{7'b0001000, 4'hA};
      tbl[11] = '{7'b0000011, 4'hB};
      tbl[12] = '{7'b1000110, 4'hC};
      tbl[13] = '{7'b0100001, 4'hD};
      tbl[14] = '{7'b0000110, 4'hE};
      tbl[15] = '{7'b0001110, 4'hF};

      bus.seg_n = '1;
      bus.an_n  = '1;
      repeat (3) @(negedge clk);
      chk("init_hex_out",     32'(bus.hex_out), 0);
      chk("init_digit_valid", 32'(bus.digit_valid), 0);
      chk("init_update",      32'(bus.update), 0);
      chk("init_bad_pattern", 32'(bus.bad_pattern), 0);
      rst = 1'b0;
      @(negedge clk);

      // Full decode sweep on digit 2
      for (int i = 0; i < 16; i++) begin
         hold(tbl[i].seg, 4'b1011, N + 1);
         chk("sweep_nibble", 32'(bus.hex_out[11:8]), 32'(tbl[i].nib));
      end

      // Reset in the middle of settling discards the partial count
      hold(7'b0100100, 4'b1110, 2);
      pulse_reset();
      hold(7'b0100100, 4'b1110, N + 1);
      chk("post_rst_nibble", 32'(bus.hex_out[3:0]), 2);
      chk("post_rst_valid",  32'(bus.digit_valid), 32'(4'b0001));

      // Glitches: change after 2 edges and after N edges, never captured early
      hold(7'b0110000, 4'b0111, 2);
      hold(7'b0010010, 4'b0111, N + 1);
      hold(7'b1111001, 4'b0111, N);
      hold(7'b0000010, 4'b0111, N + 1);
      chk("glitch_nibble", 32'(bus.hex_out[15:12]), 6);

      // Illegal pattern leaves previous value on digit 1
      hold(7'b1011000, 4'b1101, N + 1);
      hold(7'b1010101, 4'b1101, N + 1);
      chk("bad_keeps_hex",   32'(bus.hex_out[7:4]), 7);
      chk("bad_keeps_valid", 32'(bus.digit_valid[1]), 1);

      // Blank clears valid; ghosting is ignored
      hold(7'b1111111, 4'b1110, N + 1);
      chk("blank_valid", 32'(bus.digit_valid[0]), 0);
      hold(7'b0000000, 4'b1100, 10);

      // Long hold recaptures nothing; returning after one different sample does
      hold(7'b0001000, 4'b1110, N + 1);
      hold(7'b0001000, 4'b1110, 6);
      hold(7'b0000011, 4'b1110, 1);
      hold(7'b0001000, 4'b1110, N + 1);
      chk("return_nibble", 32'(bus.hex_out[3:0]), 32'hA);

      // Scan 1,2,3,4 across the digits
      for (int k = 0; k < 4; k++) hold(tbl[k+1].seg, ~(4'b0001 << k), 8);
      chk("scan_hex_out",     32'(bus.hex_out), 32'h4321);
      chk("scan_digit_valid", 32'(bus.digit_valid), 32'hF);

      hold(7'b1111111, 4'b1111, 4);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-segment encoder: observes a multiplexed, active-low 7-segment display bus (segment lines plus per-digit enables) and recovers the hex nibble shown on each digit. Each pattern must be stable for a programmable number of cycles before it is accepted. Accepted values go into a per-digit register file with valid flags. The block sits on the verification and self-check path, read back by game logic or a bench to confirm what the display is actually showing.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (≥1).
- STABLE_CYCLES, 3: consecutive matching samples required before capture (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- seg_n  input  7  active-low segments, bit 6 = g … bit 0 = a.
- an_n  input  DIGITS  active-low digit enables; a digit is selected when exactly one bit is low.
- hex_out  output  4*DIGITS  decoded nibbles; digit k occupies bits [4k+3:4k].
- digit_valid  output  DIGITS  bit k = 1 when digit k holds a decoded value.
- update  output  1  one-cycle pulse on each capture (decoded, blank or bad).
- upd_digit  output  max(1,ceil(log2 DIGITS))  index of the digit captured with update.
- bad_pattern  output  1  one-cycle pulse when the captured pattern is not legal.

## Operation
- The input register samples {seg_n, an_n} every cycle. On reset it loads all ones, meaning blank with no digit selected.
- A sample is **selectable** when the sampled an_n has exactly one zero bit.
- FSM states:
  - IDLE: sample not selectable. cnt = 0.
  - SETTLE: selectable sample seen. cnt counts matching samples.
  - HOLD: value captured. Waiting for a change.
- Transitions, evaluated each edge on the new sample vs the previous sample:
  - not selectable → IDLE, cnt = 0.
  - selectable and differs from the previous sample → SETTLE, cnt = 0.
  - SETTLE and equal: cnt + 1. When cnt reaches STABLE_CYCLES, capture → HOLD.
  - HOLD and equal: stay. No re-capture.
- Capture on digit k: update = 1, upd_digit = k.
- Decode table (seg_n → hex):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1011000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
- Capture effect by pattern:
  - Legal pattern: hex_out[k] is written and digit_valid[k] is set.
  - 1111111 (blank): digit_valid[k] is cleared, hex_out[k] is unchanged, no error.
  - Any other pattern: bad_pattern pulses, hex_out[k] and digit_valid[k] are unchanged.
- Other digits are never modified by a capture on digit k.
- Two or more enables low (ghosting) is treated as not selectable. No capture and no error.

## Timing
- Reset values: hex_out = 0, digit_valid = 0, update = 0, upd_digit = 0, bad_pattern = 0, state IDLE, cnt = 0.
- Reset is effective immediately and asynchronously, including mid-SETTLE. A partial count is discarded.
- Latency: let the input hold a new constant value across rising edges e1..e(N+1), where N = STABLE_CYCLES.
  - e1 loads the sample.
  - e2..e(N+1) count matching samples.
  - hex_out, digit_valid, update and bad_pattern change at e(N+1).
  - With the default N = 3 this is the 4th edge.
- A change at any edge before e(N+1) restarts the count. The value is never captured early.
- update and bad_pattern are high for exactly one cycle. There is at most one capture per stable period.
- A return to the identical value after any different sample is a new period and is captured again.
- The counter saturates and never wraps.

## Configuration
- SEG7_DP_EN defined:
  - Adds input seg_dp_n (1 bit, active-low decimal point), sampled and compared alongside seg_n.
  - Adds output dp_out (DIGITS bits). dp_out[k] = ~seg_dp_n, written on every capture of digit k (legal, blank or bad). Reset value 0.
- SEG7_DP_EN undefined: neither port exists. Behaviour is otherwise identical.

## Test plan
- Reset mid-SETTLE: an_n = 1110, seg_n = 0100100 held 2 cycles, then rst pulse → all outputs 0. After release and 4 held edges: hex_out[3:0] = 2, digit_valid = 0001, update pulses once.
- Full decode sweep: for each of the 16 patterns on digit 2, held 4 edges → hex_out[11:8] matches the table and upd_digit = 2.
- Glitch: pattern changes after 2 edges → no update until the new value has been held for 4 edges.
- Illegal pattern 1010101 on digit 1 (previously 7) → bad_pattern pulses, hex_out[7:4] stays 7, digit_valid[1] stays 1.
- Blank 1111111 on digit 0 → digit_valid[0] = 0, no bad_pattern. Ghost enables an_n = 1100 held 10 cycles → no update.
- Scan all 4 digits showing 1, 2, 3, 4 with 8 cycles per digit → hex_out = 0x4321, digit_valid = 1111, exactly one update per dwell.
